// File: rtl/led_status_ctrl_pkg.sv
// Shared types and default timing for the status LED controller.
// Default timing assumes a 100 MHz clock and a 125 ms blink unit.
package led_status_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV  = 12_500_000;
  localparam int DEF_ON_UNITS  = 2;
  localparam int DEF_OFF_UNITS = 2;
  localparam int DEF_GAP_UNITS = 8;
  localparam int DEF_CODE_W    = 4;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/led_status_ctrl_unit_tick_gen.sv
// Blink-unit prescaler: one-cycle tick every TICK_DIV cycles.
// A synchronous clear restarts the count at zero.
module unit_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] cnt;
  logic          last;

  assign last = (cnt == TW'(TICK_DIV - 1));
  assign tick = last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Status LED driver: heartbeat passthrough, or a blink code
// of N pulses plus a long gap while a fault code is present.
module led_status_ctrl
  import led_status_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_UNITS  = DEF_ON_UNITS,
  parameter int OFF_UNITS = DEF_OFF_UNITS,
  parameter int GAP_UNITS = DEF_GAP_UNITS,
  parameter int CODE_W    = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  input  logic [CODE_W-1:0] fault_code,
  output logic              led_out,
  output logic              busy,
  output logic              code_done
);

  localparam int UMAX = max3(ON_UNITS, OFF_UNITS, GAP_UNITS);
  localparam int UW   = $clog2(UMAX + 1);

  state_t            state;
  logic [CODE_W-1:0] cur_code;
  logic [CODE_W-1:0] pulse_cnt;
  logic [UW-1:0]     unit_cnt;
  logic [UW-1:0]     unit_last;
  logic              tick;
  logic              unit_end;
  logic              tick_clr;
  logic              has_fault;

  assign has_fault = (fault_code != '0);

  always_comb begin
    unit_last = '0;
    unique case (state)
      S_IDLE: unit_last = '0;
      S_ON:   unit_last = UW'(ON_UNITS - 1);
      S_OFF:  unit_last = UW'(OFF_UNITS - 1);
      S_GAP:  unit_last = UW'(GAP_UNITS - 1);
    endcase
  end

  assign unit_end = tick && (unit_cnt == unit_last)
                    && (state != S_IDLE);

  // Prescaler is held in IDLE and restarted on every state change.
  assign tick_clr = (state == S_IDLE) || unit_end;

  unit_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      led_out   <= 1'b0;
      busy      <= 1'b0;
      code_done <= 1'b0;
      cur_code  <= '0;
      pulse_cnt <= '0;
      unit_cnt  <= '0;
    end else begin
      code_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unit_cnt  <= '0;
          pulse_cnt <= '0;
          if (has_fault) begin
            cur_code <= fault_code;
            state    <= S_ON;
            led_out  <= 1'b1;
            busy     <= 1'b1;
          end else begin
            led_out <= pwm_in;
            busy    <= 1'b0;
          end
        end
        S_ON: begin
          if (unit_end) begin
            unit_cnt  <= '0;
            pulse_cnt <= pulse_cnt + CODE_W'(1);
            led_out   <= 1'b0;
            if (pulse_cnt == cur_code - CODE_W'(1)) begin
              state <= S_GAP;
            end else begin
              state <= S_OFF;
            end
          end else if (tick) begin
            unit_cnt <= unit_cnt + UW'(1);
          end
        end
        S_OFF: begin
          if (unit_end) begin
            unit_cnt <= '0;
            state    <= S_ON;
            led_out  <= 1'b1;
          end else if (tick) begin
            unit_cnt <= unit_cnt + UW'(1);
          end
        end
        S_GAP: begin
          if (unit_end) begin
            unit_cnt  <= '0;
            pulse_cnt <= '0;
            code_done <= 1'b1;
            if (has_fault) begin
              cur_code <= fault_code;
              state    <= S_ON;
              led_out  <= 1'b1;
            end else begin
              cur_code <= '0;
              state    <= S_IDLE;
              led_out  <= pwm_in;
              busy     <= 1'b0;
            end
          end else if (tick) begin
            unit_cnt <= unit_cnt + UW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: random pwm/fault stimulus checked
// against a queue-based blink-pattern model, plus period checks.
module tb_led_status_ctrl;

  localparam int TD   = 4;
  localparam int ONU  = 2;
  localparam int OFFU = 2;
  localparam int GAPU = 8;
  localparam int CW   = 4;

  logic          clk;
  logic          reset;
  logic          pwm_in;
  logic [CW-1:0] fault_code;
  logic          led_out;
  logic          busy;
  logic          code_done;

  led_status_ctrl #(
    .TICK_DIV  (TD),
    .ON_UNITS  (ONU),
    .OFF_UNITS (OFFU),
    .GAP_UNITS (GAPU),
    .CODE_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .fault_code (fault_code),
    .led_out    (led_out),
    .busy       (busy),
    .code_done  (code_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int last_done = -1;
  int chk_period = 0;

  bit   q[$];
  bit   act;
  logic m_led;
  logic m_busy;
  logic m_done;

  // Expected LED level for every cycle of one code.
  function automatic void fill(input int n);
    for (int p = 1; p <= n; p++) begin
      repeat (ONU * TD) q.push_back(1'b1);
      if (p < n) repeat (OFFU * TD) q.push_back(1'b0);
    end
    repeat (GAPU * TD) q.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    if (reset) begin
      q.delete();
      act    = 1'b0;
      m_led  = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (q.size() == 0) begin
        if (act) m_done = 1'b1;
        if (fault_code != '0) begin
          fill(int'(fault_code));
          m_led = q.pop_front();
          act   = 1'b1;
        end else begin
          m_led = pwm_in;
          act   = 1'b0;
        end
      end else begin
        m_led = q.pop_front();
      end
      m_busy = act;
    end
  endfunction

  task automatic cyc();
    pwm_in = 1'($urandom);
    @(posedge clk);
    model_edge();
    cyc_n++;
    @(negedge clk);
    n_assert++;
    assert (led_out === m_led) else begin
      n_fail++;
      $error("FAIL led cyc=%0d got=%b exp=%b", cyc_n, led_out, m_led);
    end
    n_assert++;
    assert (busy === m_busy) else begin
      n_fail++;
      $error("FAIL busy cyc=%0d got=%b exp=%b", cyc_n, busy, m_busy);
    end
    n_assert++;
    assert (code_done === m_done) else begin
      n_fail++;
      $error("FAIL done cyc=%0d got=%b exp=%b", cyc_n, code_done, m_done);
    end
    if (code_done === 1'b1) begin
      if (chk_period != 0 && last_done >= 0) begin
        n_assert++;
        assert (cyc_n - last_done == chk_period) else begin
          n_fail++;
          $error("FAIL period got=%0d exp=%0d",
                 cyc_n - last_done, chk_period);
        end
      end
      last_done = cyc_n;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic phase(input int per);
    chk_period = per;
    last_done  = -1;
  endtask

  initial begin
    reset      = 1'b1;
    fault_code = '0;
    pwm_in     = 1'b0;
    act        = 1'b0;
    m_led      = 1'b0;
    m_busy     = 1'b0;
    m_done     = 1'b0;

    // 1: reset with pwm toggling, then heartbeat passthrough
    run(10);
    reset = 1'b0;
    run(20);

    // 2: code 3 held
    phase(72);
    fault_code = 4'd3;
    run(3 * 72 + 4);
    fault_code = '0;
    run(80);

    // 3: code 3 for one cycle only
    phase(0);
    fault_code = 4'd3;
    cyc();
    fault_code = '0;
    run(90);

    // 4: 2 -> 5 during the second ON pulse
    phase(0);
    fault_code = 4'd2;
    run(20);
    fault_code = 4'd5;
    run(50);
    fault_code = '0;
    run(110);

    // 5: reset in the middle of OFF
    fault_code = 4'd3;
    run(12);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run(20);
    fault_code = '0;
    run(80);

    // 6: max code
    phase(264);
    fault_code = 4'd15;
    run(2 * 264 + 4);
    fault_code = '0;
    run(270);

    // 7: random codes and occasional resets
    phase(0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        fault_code = CW'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
